// File: rtl/pswd_update_pkg.sv
// Shared constants and types for the password store.
// The authentication path imports the same package, so the stored and the
// compared password formats cannot drift apart.
package pswd_update_pkg;

    localparam int PSWD_DIGITS    = 6;
    localparam int DIGIT_WIDTH    = 4;
    localparam int PSWD_WIDTH     = PSWD_DIGITS * DIGIT_WIDTH;
    localparam int ADDR_WIDTH     = 5;
    localparam int PLAYER_WIDTH   = 3;
    localparam int PSWD_BASE_ADDR = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ENTER_NEW  = 3'd1,
        ST_ENTER_CONF = 3'd2,
        ST_CHECK      = 3'd3,
        ST_WRITE      = 3'd4,
        ST_DONE       = 3'd5,
        ST_FAIL       = 3'd6
    } state_t;

    // RAM word address of a player's password; wraps modulo the address space.
    function automatic logic [ADDR_WIDTH-1:0] slot_addr(
        input int                      base,
        input logic [PLAYER_WIDTH-1:0] id
    );
        int sum;
        sum = base + int'(id);
        return sum[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/pswd_update_digit_shifter.sv
// Collects one password entry: digits shift in MSB-first, so the first digit
// typed ends up in the top nibble. The counter wraps to zero on the last digit,
// which leaves the shifter ready for a fresh entry without an extra clear.
module pswd_digit_shifter
    import pswd_update_pkg::*;
#(
    parameter int DIGITS = PSWD_DIGITS
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clear,
    input  logic                          i_load,
    input  logic [DIGIT_WIDTH-1:0]        i_digit,
    output logic [DIGIT_WIDTH*DIGITS-1:0] o_word,
    output logic                          o_last
);

    localparam int WORD_W = DIGIT_WIDTH * DIGITS;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_count;
    logic              w_last;

    // The digit being accepted now completes the entry.
    assign w_last = i_load && !i_clear && (r_count == CNT_LAST);

    // Shift register and digit counter; clear beats load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_word  <= {r_word[WORD_W-DIGIT_WIDTH-1:0], i_digit};
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign o_word = r_word;
    assign o_last = w_last;

endmodule

// File: rtl/pswd_update.sv
// Password-change writer. A logged-in registered player enters a new password
// twice on the keypad; when both entries agree the word is written into that
// player's slot of the password RAM. Logout or loss of the session abandons the
// change silently; guests, mismatches and keypad inactivity report a failure.
module pswd_update
    import pswd_update_pkg::*;
#(
    parameter int PSWD_BASE      = PSWD_BASE_ADDR,
    parameter int DIGITS         = PSWD_DIGITS,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          LoggedIn,
    input  logic [PLAYER_WIDTH-1:0]       PlayerID,
    input  logic                          isGuest,
    input  logic                          logout,
    input  logic                          ChangeReq,
    input  logic                          UserLoad,
    input  logic [DIGIT_WIDTH-1:0]        UserDigit,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DIGIT_WIDTH*DIGITS-1:0] wr_data,
    output logic                          Busy,
    output logic                          UpdateDone,
    output logic                          UpdateFail,
    output logic                          ChangeLED
);

    localparam int WORD_W = DIGIT_WIDTH * DIGITS;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    logic [PLAYER_WIDTH-1:0] r_slot;
    logic [TMO_W-1:0]        r_tmo;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [WORD_W-1:0]       r_wr_data;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_fail;
    logic                    r_led;

    logic                    w_abort;
    logic                    w_entry;
    logic                    w_start;
    logic                    w_tmo_hit;
    logic                    w_clear;
    logic                    w_new_load;
    logic                    w_conf_load;
    logic                    w_new_last;
    logic                    w_conf_last;
    logic                    w_match;
    logic [WORD_W-1:0]       w_new_word;
    logic [WORD_W-1:0]       w_conf_word;

    // Session loss outranks everything else, including a digit in the same cycle.
    assign w_abort     = (r_state != ST_IDLE) && (logout || !LoggedIn);
    assign w_entry     = (r_state == ST_ENTER_NEW) || (r_state == ST_ENTER_CONF);
    assign w_start     = (r_state == ST_IDLE) && ChangeReq && LoggedIn && !isGuest;
    // A digit arriving on the expiry cycle restarts the count instead of failing.
    assign w_tmo_hit   = w_entry && !UserLoad && (r_tmo == TMO_LAST);
    assign w_clear     = w_start || w_abort || w_tmo_hit;
    assign w_new_load  = (r_state == ST_ENTER_NEW) && UserLoad;
    assign w_conf_load = (r_state == ST_ENTER_CONF) && UserLoad;
    assign w_match     = (w_new_word == w_conf_word);

    pswd_digit_shifter #(
        .DIGITS (DIGITS)
    ) u_new_shifter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (w_clear),
        .i_load  (w_new_load),
        .i_digit (UserDigit),
        .o_word  (w_new_word),
        .o_last  (w_new_last)
    );

    pswd_digit_shifter #(
        .DIGITS (DIGITS)
    ) u_conf_shifter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (w_clear),
        .i_load  (w_conf_load),
        .i_digit (UserDigit),
        .o_word  (w_conf_word),
        .o_last  (w_conf_last)
    );

    // Change sequencer; every output is registered from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_slot    <= '0;
            r_tmo     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_led     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_tmo   <= '0;
                r_busy  <= 1'b0;
                r_led   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ChangeReq) begin
                            if (w_start) begin
                                r_state <= ST_ENTER_NEW;
                                r_slot  <= PlayerID;
                                r_tmo   <= '0;
                                r_busy  <= 1'b1;
                                r_led   <= 1'b1;
                            end else begin
                                r_state <= ST_FAIL;
                                r_fail  <= 1'b1;
                            end
                        end
                    end
                    ST_ENTER_NEW, ST_ENTER_CONF: begin
                        if (UserLoad) begin
                            r_tmo <= '0;
                            if (w_new_last) begin
                                r_state <= ST_ENTER_CONF;
                            end else if (w_conf_last) begin
                                r_state <= ST_CHECK;
                                r_led   <= 1'b0;
                            end
                        end else if (w_tmo_hit) begin
                            r_state <= ST_FAIL;
                            r_tmo   <= '0;
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_led   <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (w_match) begin
                            r_state   <= ST_WRITE;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= slot_addr(PSWD_BASE, r_slot);
                            r_wr_data <= w_new_word;
                        end else begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_WRITE: begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_FAIL: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_led   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign Busy       = r_busy;
    assign UpdateDone = r_done;
    assign UpdateFail = r_fail;
    assign ChangeLED  = r_led;

endmodule

// File: tb/tb_pswd_update.sv
// Bench for pswd_update: random and directed password changes, with a
// queue of expected write/done/fail events checked by an independent monitor.
module tb_pswd_update;

    localparam int BASE    = 0;
    localparam int TMO     = 20;
    localparam int EV_WRITE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_FAIL  = 2;

    typedef logic [3:0] dig_t [6];
    typedef struct {
        int kind;
        int cyc;
        int addr;
        int data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        LoggedIn;
    logic [2:0]  PlayerID;
    logic        isGuest;
    logic        logout;
    logic        ChangeReq;
    logic        UserLoad;
    logic [3:0]  UserDigit;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic        Busy;
    logic        UpdateDone;
    logic        UpdateFail;
    logic        ChangeLED;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   mon_kind;
    exp_t mon_e;

    pswd_update #(
        .PSWD_BASE      (BASE),
        .DIGITS         (6),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .LoggedIn   (LoggedIn),
        .PlayerID   (PlayerID),
        .isGuest    (isGuest),
        .logout     (logout),
        .ChangeReq  (ChangeReq),
        .UserLoad   (UserLoad),
        .UserDigit  (UserDigit),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .Busy       (Busy),
        .UpdateDone (UpdateDone),
        .UpdateFail (UpdateFail),
        .ChangeLED  (ChangeLED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write/done/fail pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && (wr_en || UpdateDone || UpdateFail)) begin
            mon_kind = wr_en ? EV_WRITE : (UpdateDone ? EV_DONE : EV_FAIL);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", mon_kind, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_kind != mon_e.kind || cyc != mon_e.cyc ||
                    (int'(wr_en) + int'(UpdateDone) + int'(UpdateFail)) != 1 ||
                    (mon_kind == EV_WRITE && (int'(wr_addr) != mon_e.addr || int'(wr_data) != mon_e.data))) begin
                    miscompares++;
                    $display("FAIL event: got kind %0d cyc %0d addr %0d data %06h, expected kind %0d cyc %0d addr %0d data %06h",
                             mon_kind, cyc, wr_addr, wr_data, mon_e.kind, mon_e.cyc, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int addr, input int data);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one input for a single cycle; cap is the clock edge that samples it.
    task automatic pulse_req(output int cap);
        ChangeReq = 1'b1;
        cap = cyc + 1;
        idle(1);
        ChangeReq = 1'b0;
    endtask

    task automatic key(input logic [3:0] d, output int cap);
        UserLoad  = 1'b1;
        UserDigit = d;
        cap = cyc + 1;
        idle(1);
        UserLoad  = 1'b0;
        UserDigit = 4'($urandom_range(0, 15));
    endtask

    // Reference: a change succeeds iff both entries agree digit for digit.
    task automatic expect_result(input int player, input dig_t nd, input dig_t cd, input int cap);
        bit same;
        int data;
        same = 1'b1;
        data = 0;
        for (int i = 0; i < 6; i++) begin
            if (nd[i] != cd[i]) same = 1'b0;
            data = data * 16 + int'(nd[i]);
        end
        if (same) begin
            push(EV_WRITE, cap + 1, (BASE + player) % 32, data);
            push(EV_DONE,  cap + 2, 0, 0);
        end else begin
            push(EV_FAIL,  cap + 1, 0, 0);
        end
    endtask

    task automatic do_change(input int player, input dig_t nd, input dig_t cd, input bit disturb);
        int cap;
        PlayerID = 3'(player);
        pulse_req(cap);
        chk("busy_in_entry", 32'(Busy), 32'd1);
        chk("led_in_entry", 32'(ChangeLED), 32'd1);
        for (int i = 0; i < 12; i++) begin
            if (disturb) idle($urandom_range(0, 3));
            if (disturb && ($urandom_range(0, 3) == 0)) PlayerID = 3'($urandom_range(0, 7));
            ChangeReq = disturb && ($urandom_range(0, 3) == 0);
            key((i < 6) ? nd[i] : cd[i-6], cap);
            ChangeReq = 1'b0;
        end
        expect_result(player, nd, cd, cap);
        idle(4);
        chk("busy_after", 32'(Busy), 32'd0);
        chk("led_after", 32'(ChangeLED), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(UpdateDone), 32'd0);
        chk({tag, "_fail"}, 32'(UpdateFail), 32'd0);
        chk({tag, "_led"}, 32'(ChangeLED), 32'd0);
    endtask

    initial begin
        dig_t a, b;
        int   cap;
        int   player;

        rst = 1'b0;
        LoggedIn = 1'b0;
        PlayerID = 3'd0;
        isGuest = 1'b0;
        logout = 1'b0;
        ChangeReq = 1'b0;
        UserLoad = 1'b0;
        UserDigit = 4'd0;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b1;
        LoggedIn = 1'b1;
        idle(2);

        // Matching entries for player 3
        a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        do_change(3, a, a, 1'b0);

        // Confirm differs in the last digit
        b = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
        do_change(3, a, b, 1'b0);

        // Guest session is refused
        isGuest = 1'b1;
        pulse_req(cap);
        push(EV_FAIL, cap, 0, 0);
        chk("guest_led", 32'(ChangeLED), 32'd0);
        chk("guest_busy", 32'(Busy), 32'd0);
        idle(3);
        isGuest = 1'b0;

        // Not logged in is refused
        LoggedIn = 1'b0;
        pulse_req(cap);
        push(EV_FAIL, cap, 0, 0);
        idle(3);
        LoggedIn = 1'b1;

        // Keypad inactivity after three digits
        PlayerID = 3'd2;
        pulse_req(cap);
        for (int i = 0; i < 3; i++) key(4'(i + 9), cap);
        push(EV_FAIL, cap + TMO, 0, 0);
        idle(TMO + 4);
        chk("tmo_busy", 32'(Busy), 32'd0);
        a = '{4'd0, 4'd15, 4'd7, 4'd8, 4'd1, 4'd14};
        do_change(5, a, a, 1'b0);

        // Logout together with the third confirm digit
        PlayerID = 3'd4;
        pulse_req(cap);
        for (int i = 0; i < 8; i++) key(4'(i), cap);
        logout = 1'b1;
        key(4'd8, cap);
        logout = 1'b0;
        chk("logout_busy", 32'(Busy), 32'd0);
        chk("logout_led", 32'(ChangeLED), 32'd0);
        idle(4);

        // Session drops mid entry
        pulse_req(cap);
        key(4'd3, cap);
        key(4'd4, cap);
        LoggedIn = 1'b0;
        idle(1);
        chk("drop_busy", 32'(Busy), 32'd0);
        LoggedIn = 1'b1;
        idle(3);

        // Asynchronous reset while confirming, then a clean change for player 0
        pulse_req(cap);
        for (int i = 0; i < 8; i++) key(4'(i + 1), cap);
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        idle(1);
        rst = 1'b1;
        idle(1);
        a = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        do_change(0, a, a, 1'b0);

        // Randomized changes with stray keys, mid-entry PlayerID swaps and ignored requests
        for (int t = 0; t < 25; t++) begin
            player = $urandom_range(0, 7);
            for (int i = 0; i < 6; i++) a[i] = 4'($urandom_range(0, 15));
            b = a;
            if ($urandom_range(0, 1) == 1) begin
                int j;
                j = $urandom_range(0, 5);
                b[j] = a[j] ^ 4'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 2) == 0) key(4'($urandom_range(0, 15)), cap);
            do_change(player, a, b, 1'b1);
        end

        idle(5);
        chk("pending_events", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pswd_update.md
Name: pswd_update

Overview:
- Password-change writer paired with the login authentication path.
- Once a registered player is logged in, it collects a new 6-digit password entered twice (new, then confirm) from the same keypad interface (UserLoad/UserDigit).
- On match it writes the 24-bit password word into the password RAM slot for that player.
- Sits beside the authentication block and drives the write port of the password store.

Parameters:
- PSWD_BASE, 0, RAM address of player 0's password word; slot = PSWD_BASE + PlayerID.
- DIGITS, 6, digits per password (4 bits each, so word width 24).
- TIMEOUT_CYCLES, 50_000_000, idle cycles with no UserLoad during entry before the change aborts.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- LoggedIn  input  1  level; session active
- PlayerID  input  3  logged-in player index, valid while LoggedIn
- isGuest  input  1  level; guest session (no stored password)
- logout  input  1  pulse; session ending
- ChangeReq  input  1  pulse; request a password change
- UserLoad  input  1  pulse, one cycle per digit (already debounced/one-shot)
- UserDigit  input  4  digit value, sampled when UserLoad=1
- wr_en  output  1  RAM write strobe, one cycle
- wr_addr  output  5  RAM write address
- wr_data  output  24  new password word
- Busy  output  1  high while a change is in progress
- UpdateDone  output  1  one-cycle pulse on successful write
- UpdateFail  output  1  one-cycle pulse on rejected or aborted change
- ChangeLED  output  1  high in ENTER_NEW/ENTER_CONF (operator prompt)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0; new/confirm registers 0; digit count 0; timeout counter 0.
- States: IDLE, ENTER_NEW, ENTER_CONF, CHECK, WRITE, DONE, FAIL.
- IDLE:
  - ChangeReq & LoggedIn & ~isGuest -> ENTER_NEW. Latch PlayerID into slot register; clear shift registers and count.
  - ChangeReq with ~LoggedIn or isGuest -> FAIL.
  - ChangeReq without LoggedIn -> FAIL.
- ENTER_NEW:
  - Each UserLoad shifts UserDigit in MSB-first: new = {new[19:0], UserDigit}. The first digit ends in [23:20].
  - Count increments. When the 6th digit is accepted (count becomes DIGITS), go to ENTER_CONF next cycle with count cleared.
- ENTER_CONF: same shifting into the confirm register; on the 6th digit -> CHECK.
- CHECK (1 cycle): new==confirm -> WRITE, else FAIL.
- WRITE (1 cycle):
  - wr_en=1, wr_addr=PSWD_BASE+slot (5-bit, wraps mod 32), wr_data=new.
  - wr_addr/wr_data are registered and held stable through that cycle.
  - Next state DONE.
- DONE (1 cycle): UpdateDone=1 -> IDLE.
- FAIL (1 cycle): UpdateFail=1 -> IDLE. No write ever issued from a FAIL path.
- Busy=1 in ENTER_NEW, ENTER_CONF, CHECK, WRITE.
- Latency: 6th confirm digit at cycle N -> CHECK at N+1 -> wr_en at N+2 -> UpdateDone at N+3.
- Timeout:
  - Counter runs in ENTER_NEW/ENTER_CONF, cleared by each UserLoad and on state entry.
  - Reaching TIMEOUT_CYCLES-1 -> FAIL.
- Abort:
  - logout, or LoggedIn falling, in any non-IDLE state -> IDLE directly.
  - No UpdateFail pulse, no write; registers cleared.
  - logout has priority over UserLoad in the same cycle.
- Other boundary cases:
  - ChangeReq while Busy is ignored.
  - UserLoad in IDLE/CHECK/WRITE/DONE/FAIL is ignored.
  - UserLoad and timeout expiry in the same cycle: the digit wins and the counter clears.
- Digit values 0–15 are accepted unfiltered; they match authentication's stored format.
- Slot latched at start; a PlayerID change mid-operation does not affect wr_addr.

Decomposition:
- Shared package: state encoding, DIGITS, PSWD_WIDTH=24, ADDR_WIDTH=5, PSWD_BASE. The authentication block imports the same constants so stored and compared formats agree.
- One natural sub-module: pswd_digit_shifter. It holds the 24-bit shift register and digit counter with clear/load/full outputs, instantiated twice (new, confirm).
- Timeout counter inline.

Test Plan:
- Player 3 logged in (PSWD_BASE=0); ChangeReq, digits 1,2,3,4,5,6 then 1,2,3,4,5,6 -> exactly one wr_en with wr_addr=5'd3, wr_data=24'h123456; UpdateDone 1 cycle later; Busy low after.
- Same flow, confirm 1,2,3,4,5,7 -> no wr_en; UpdateFail pulses once, 1 cycle after the 6th confirm digit (CHECK).
- isGuest=1, ChangeReq -> UpdateFail pulse within 2 cycles; no ChangeLED; state stays IDLE.
- TIMEOUT_CYCLES=20: ChangeReq, 3 digits, then idle 20 cycles -> UpdateFail; no wr_en; the next ChangeReq starts from digit count 0.
- logout asserted after the 2nd confirm digit (same cycle as a UserLoad) -> IDLE next cycle; no wr_en, no UpdateFail; Busy=0.
- rst driven low mid-ENTER_CONF (asynchronously, between clock edges) -> all outputs 0 immediately; after release, a full change to 24'h987654 for player 0 writes addr 0 correctly.
